// File: rtl/l1_memory_banked_if.sv
// rtl/l1_memory_banked_if.sv - one requester port of the banked L1 memory
interface l1_memory_banked_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  en;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_w;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  delay;

    modport master (
        output en, we, be, addr, data_w,
        input  data_r, delay
    );

    modport slave (
        input  en, we, be, addr, data_w,
        output data_r, delay
    );
endinterface

// File: rtl/l1_memory_banked.sv
// rtl/l1_memory_banked.sv - two-port L1 memory over word-interleaved single-port banks
// Same-bank requests are serialised by a round-robin pointer; the loser sees delay=1.
module l1_memory_banked #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_BANKS    = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    l1_memory_banked_if.slave    a,
    l1_memory_banked_if.slave    b
);
    localparam int BE_WIDTH   = DATA_WIDTH / 8;
    localparam int LOG2B      = $clog2(NUM_BANKS);
    localparam int BANK_BITS  = (LOG2B > 0) ? LOG2B : 1;
    localparam int NUM_SLOTS  = 1 << BANK_BITS;
    localparam int ROW_BITS   = ADDR_WIDTH - LOG2B;
    localparam int BANK_DEPTH = 1 << ROW_BITS;

    typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

    pri_t                  rr, rr_next;
    logic                  conflict, a_grant, b_grant;
    logic [BANK_BITS-1:0]  a_bank, b_bank;
    logic [ROW_BITS-1:0]   a_row, b_row;
    logic                  a_rd, b_rd;
    logic [DATA_WIDTH-1:0] a_word, b_word;
    logic [NUM_SLOTS-1:0][DATA_WIDTH-1:0] bank_rd;

    // With a single bank the mask forces every request onto bank 0.
    assign a_bank = a.addr[BANK_BITS-1:0] & BANK_BITS'(NUM_BANKS - 1);
    assign b_bank = b.addr[BANK_BITS-1:0] & BANK_BITS'(NUM_BANKS - 1);
    assign a_row  = a.addr[ADDR_WIDTH-1:LOG2B];
    assign b_row  = b.addr[ADDR_WIDTH-1:LOG2B];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr <= PRI_A;
        else        rr <= rr_next;
    end

    always_comb begin
        conflict = a.en && b.en && (a_bank == b_bank);
        a_grant  = a.en && !(conflict && (rr == PRI_B));
        b_grant  = b.en && !(conflict && (rr == PRI_A));
        rr_next  = rr;
        if (conflict) rr_next = (rr == PRI_A) ? PRI_B : PRI_A;
    end

    assign a.delay = a.en && !a_grant;
    assign b.delay = b.en && !b_grant;

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_bank
        if (k < NUM_BANKS) begin : g_real
            logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
            logic                  sel_a, sel_b, bank_we;
            logic [ROW_BITS-1:0]   row;
            logic [BE_WIDTH-1:0]   bank_be;
            logic [DATA_WIDTH-1:0] bank_wd;

            assign sel_a   = a_grant && (a_bank == BANK_BITS'(k));
            assign sel_b   = b_grant && (b_bank == BANK_BITS'(k));
            assign row     = sel_b ? b_row : a_row;
            assign bank_we = (sel_a && a.we) || (sel_b && b.we);
            assign bank_be = sel_b ? b.be : a.be;
            assign bank_wd = sel_b ? b.data_w : a.data_w;

            always_ff @(posedge clk) begin
                if (bank_we) begin
                    for (int i = 0; i < BE_WIDTH; i++) begin
                        if (bank_be[i]) mem[row][i*8 +: 8] <= bank_wd[i*8 +: 8];
                    end
                end
            end

            assign bank_rd[k] = mem[row];
        end else begin : g_pad
            assign bank_rd[k] = '0;
        end
    end

    assign a_rd   = a_grant && !a.we;
    assign b_rd   = b_grant && !b.we;
    assign a_word = bank_rd[a_bank];
    assign b_word = bank_rd[b_bank];

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  a_v1, b_v1;
        logic [DATA_WIDTH-1:0] a_s1, b_s1;

        // Stage 2 only advances behind a real read so writes and stalls keep data_r.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                a_v1     <= 1'b0;
                b_v1     <= 1'b0;
                a_s1     <= '0;
                b_s1     <= '0;
                a.data_r <= '0;
                b.data_r <= '0;
            end else begin
                a_v1 <= a_rd;
                b_v1 <= b_rd;
                if (a_rd) a_s1     <= a_word;
                if (b_rd) b_s1     <= b_word;
                if (a_v1) a.data_r <= a_s1;
                if (b_v1) b.data_r <= b_s1;
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                a.data_r <= '0;
                b.data_r <= '0;
            end else begin
                if (a_rd) a.data_r <= a_word;
                if (b_rd) b.data_r <= b_word;
            end
        end
    end

`ifndef SYNTHESIS
    a_dw_bytes: assert property (@(posedge clk) DATA_WIDTH % 8 == 0);
    a_banks_ok: assert property (@(posedge clk)
        (NUM_BANKS >= 1) && ((NUM_BANKS & (NUM_BANKS - 1)) == 0) &&
        (NUM_BANKS <= (1 << ADDR_WIDTH)));
    a_lat_ok:   assert property (@(posedge clk) (READ_LATENCY == 1) || (READ_LATENCY == 2));
    a_hold_a:   assert property (@(posedge clk) disable iff (!reset)
        a.delay |=> (!a.en || ($stable(a.we) && $stable(a.be) &&
                               $stable(a.addr) && $stable(a.data_w))));
    a_hold_b:   assert property (@(posedge clk) disable iff (!reset)
        b.delay |=> (!b.en || ($stable(b.we) && $stable(b.be) &&
                               $stable(b.addr) && $stable(b.data_w))));
`endif
endmodule

// File: tb/tb_l1_memory_banked.sv
// tb/tb_l1_memory_banked.sv - directed bench for l1_memory_banked (2 banks/lat 1 and 1 bank/lat 2)
module tb_l1_memory_banked;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    l1_memory_banked_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ia1 ();
    l1_memory_banked_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ib1 ();
    l1_memory_banked_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ia2 ();
    l1_memory_banked_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ib2 ();

    l1_memory_banked #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_BANKS(2), .READ_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(rst_n), .a(ia1), .b(ib1)
    );
    l1_memory_banked #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_BANKS(1), .READ_LATENCY(2)) u_lat2 (
        .clk(clk), .reset(rst_n), .a(ia2), .b(ib2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drv_a1(input logic en, input logic we, input logic [3:0] be,
                          input logic [9:0] addr, input logic [31:0] d);
        ia1.en = en; ia1.we = we; ia1.be = be; ia1.addr = addr; ia1.data_w = d;
    endtask

    task automatic drv_b1(input logic en, input logic we, input logic [3:0] be,
                          input logic [9:0] addr, input logic [31:0] d);
        ib1.en = en; ib1.we = we; ib1.be = be; ib1.addr = addr; ib1.data_w = d;
    endtask

    task automatic drv_a2(input logic en, input logic we, input logic [3:0] be,
                          input logic [9:0] addr, input logic [31:0] d);
        ia2.en = en; ia2.we = we; ia2.be = be; ia2.addr = addr; ia2.data_w = d;
    endtask

    task automatic drv_b2(input logic en, input logic we, input logic [3:0] be,
                          input logic [9:0] addr, input logic [31:0] d);
        ib2.en = en; ib2.we = we; ib2.be = be; ib2.addr = addr; ib2.data_w = d;
    endtask

    task automatic idle_all();
        drv_a1(0, 0, 4'h0, 10'd0, 32'h0);
        drv_b1(0, 0, 4'h0, 10'd0, 32'h0);
        drv_a2(0, 0, 4'h0, 10'd0, 32'h0);
        drv_b2(0, 0, 4'h0, 10'd0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        #3;
        checks++; if (ia1.data_r !== 32'h0) begin errors++; $display("FAIL reset_a1_data got %h exp %h", ia1.data_r, 32'h0); end
        checks++; if (ib1.data_r !== 32'h0) begin errors++; $display("FAIL reset_b1_data got %h exp %h", ib1.data_r, 32'h0); end
        checks++; if (ia2.data_r !== 32'h0) begin errors++; $display("FAIL reset_a2_data got %h exp %h", ia2.data_r, 32'h0); end
        checks++; if ({ia1.delay, ib1.delay, ia2.delay, ib2.delay} !== 4'b0000) begin
            errors++; $display("FAIL reset_delays got %b exp 0000", {ia1.delay, ib1.delay, ia2.delay, ib2.delay});
        end
        mid();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        drv_a1(1, 1, 4'hF, 10'd4, 32'hDEADBEEF);
        mid();
        checks++; if (ia1.delay !== 1'b0) begin errors++; $display("FAIL wr_delay got %b exp 0", ia1.delay); end
        step();
        drv_a1(1, 0, 4'h0, 10'd4, 32'h0);
        mid();
        checks++; if (ia1.delay !== 1'b0) begin errors++; $display("FAIL rd_delay got %b exp 0", ia1.delay); end
        checks++; if (ia1.data_r !== 32'h0) begin errors++; $display("FAIL wr_no_change got %h exp %h", ia1.data_r, 32'h0); end
        step();
        drv_a1(0, 0, 4'h0, 10'd0, 32'h0);
        mid();
        checks++; if (ia1.data_r !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_after_wr got %h exp %h", ia1.data_r, 32'hDEADBEEF); end
    endtask

    task automatic test_byte_enables();
        step();
        drv_a1(1, 1, 4'hF, 10'd6, 32'h11223344);
        step();
        drv_a1(1, 1, 4'b0101, 10'd6, 32'hAABBCCDD);
        step();
        drv_a1(1, 0, 4'h0, 10'd6, 32'h0);
        step();
        drv_a1(0, 0, 4'h0, 10'd0, 32'h0);
        mid();
        checks++; if (ia1.data_r !== 32'h11BB33DD) begin errors++; $display("FAIL byte_enable got %h exp %h", ia1.data_r, 32'h11BB33DD); end
    endtask

    task automatic test_no_conflict();
        step();
        drv_a1(1, 1, 4'hF, 10'd2, 32'h22222222);
        drv_b1(1, 1, 4'hF, 10'd3, 32'h33333333);
        mid();
        checks++; if ({ia1.delay, ib1.delay} !== 2'b00) begin errors++; $display("FAIL nc_wr_delay got %b exp 00", {ia1.delay, ib1.delay}); end
        step();
        drv_a1(1, 0, 4'h0, 10'd2, 32'h0);
        drv_b1(1, 0, 4'h0, 10'd3, 32'h0);
        mid();
        checks++; if ({ia1.delay, ib1.delay} !== 2'b00) begin errors++; $display("FAIL nc_rd_delay got %b exp 00", {ia1.delay, ib1.delay}); end
        step();
        drv_a1(0, 0, 4'h0, 10'd0, 32'h0);
        drv_b1(0, 0, 4'h0, 10'd0, 32'h0);
        mid();
        checks++; if (ia1.data_r !== 32'h22222222) begin errors++; $display("FAIL nc_a_data got %h exp %h", ia1.data_r, 32'h22222222); end
        checks++; if (ib1.data_r !== 32'h33333333) begin errors++; $display("FAIL nc_b_data got %h exp %h", ib1.data_r, 32'h33333333); end
    endtask

    task automatic test_round_robin();
        step();
        drv_a1(1, 1, 4'hF, 10'd0, 32'hA0A0A0A0);
        step();
        drv_a1(1, 1, 4'hF, 10'd8, 32'hB8B8B8B8);
        step();
        drv_a1(1, 1, 4'hF, 10'd10, 32'hAAAAAAAA);
        step();
        // c1: both on bank 0, reset pointer favours A
        drv_a1(1, 0, 4'h0, 10'd0, 32'h0);
        drv_b1(1, 0, 4'h0, 10'd8, 32'h0);
        mid();
        checks++; if ({ia1.delay, ib1.delay} !== 2'b01) begin errors++; $display("FAIL rr_c1 got %b exp 01", {ia1.delay, ib1.delay}); end
        step();
        drv_a1(1, 0, 4'h0, 10'd10, 32'h0);
        mid();
        checks++; if ({ia1.delay, ib1.delay} !== 2'b10) begin errors++; $display("FAIL rr_c2 got %b exp 10", {ia1.delay, ib1.delay}); end
        checks++; if (ia1.data_r !== 32'hA0A0A0A0) begin errors++; $display("FAIL rr_c1_a_data got %h exp %h", ia1.data_r, 32'hA0A0A0A0); end
        step();
        drv_b1(1, 0, 4'h0, 10'd0, 32'h0);
        mid();
        checks++; if ({ia1.delay, ib1.delay} !== 2'b01) begin errors++; $display("FAIL rr_c3 got %b exp 01", {ia1.delay, ib1.delay}); end
        checks++; if (ib1.data_r !== 32'hB8B8B8B8) begin errors++; $display("FAIL rr_c2_b_data got %h exp %h", ib1.data_r, 32'hB8B8B8B8); end
        checks++; if (ia1.data_r !== 32'hA0A0A0A0) begin errors++; $display("FAIL rr_delay_hold got %h exp %h", ia1.data_r, 32'hA0A0A0A0); end
        step();
        drv_a1(1, 0, 4'h0, 10'd8, 32'h0);
        mid();
        checks++; if ({ia1.delay, ib1.delay} !== 2'b10) begin errors++; $display("FAIL rr_c4 got %b exp 10", {ia1.delay, ib1.delay}); end
        checks++; if (ia1.data_r !== 32'hAAAAAAAA) begin errors++; $display("FAIL rr_c3_a_data got %h exp %h", ia1.data_r, 32'hAAAAAAAA); end
        step();
        // c5: A keeps its delayed request, B moves to bank 1: no conflict
        drv_b1(1, 0, 4'h0, 10'd3, 32'h0);
        mid();
        checks++; if ({ia1.delay, ib1.delay} !== 2'b00) begin errors++; $display("FAIL rr_c5 got %b exp 00", {ia1.delay, ib1.delay}); end
        checks++; if (ib1.data_r !== 32'hA0A0A0A0) begin errors++; $display("FAIL rr_c4_b_data got %h exp %h", ib1.data_r, 32'hA0A0A0A0); end
        step();
        drv_a1(1, 0, 4'h0, 10'd0, 32'h0);
        drv_b1(1, 0, 4'h0, 10'd8, 32'h0);
        mid();
        checks++; if ({ia1.delay, ib1.delay} !== 2'b01) begin errors++; $display("FAIL rr_nc_keeps_ptr got %b exp 01", {ia1.delay, ib1.delay}); end
        checks++; if (ia1.data_r !== 32'hB8B8B8B8) begin errors++; $display("FAIL rr_c5_a_data got %h exp %h", ia1.data_r, 32'hB8B8B8B8); end
        checks++; if (ib1.data_r !== 32'h33333333) begin errors++; $display("FAIL rr_c5_b_data got %h exp %h", ib1.data_r, 32'h33333333); end
        step();
        drv_a1(0, 0, 4'h0, 10'd0, 32'h0);
        drv_b1(0, 0, 4'h0, 10'd0, 32'h0);
        mid();
        checks++; if (ia1.data_r !== 32'hA0A0A0A0) begin errors++; $display("FAIL rr_c6_a_data got %h exp %h", ia1.data_r, 32'hA0A0A0A0); end
        checks++; if (ib1.data_r !== 32'h33333333) begin errors++; $display("FAIL rr_withdraw_b got %h exp %h", ib1.data_r, 32'h33333333); end
    endtask

    task automatic test_latency2();
        step();
        drv_a2(1, 1, 4'hF, 10'd5, 32'h00000005);
        step();
        drv_a2(1, 1, 4'hF, 10'd7, 32'h00000077);
        step();
        drv_a2(1, 0, 4'h0, 10'd5, 32'h0);
        mid();
        checks++; if (ia2.delay !== 1'b0) begin errors++; $display("FAIL lat2_delay got %b exp 0", ia2.delay); end
        step();
        drv_a2(1, 1, 4'hF, 10'd7, 32'h99999999);
        mid();
        checks++; if (ia2.data_r !== 32'h0) begin errors++; $display("FAIL lat2_one_edge got %h exp %h", ia2.data_r, 32'h0); end
        step();
        drv_a2(0, 0, 4'h0, 10'd0, 32'h0);
        mid();
        checks++; if (ia2.data_r !== 32'h5) begin errors++; $display("FAIL lat2_two_edges got %h exp %h", ia2.data_r, 32'h5); end
        step();
        mid();
        checks++; if (ia2.data_r !== 32'h5) begin errors++; $display("FAIL lat2_write_hold got %h exp %h", ia2.data_r, 32'h5); end
    endtask

    task automatic test_reset_mid();
        step();
        // single bank: this conflict goes to A and moves the pointer to B
        drv_a2(1, 0, 4'h0, 10'd5, 32'h0);
        drv_b2(1, 0, 4'h0, 10'd7, 32'h0);
        mid();
        checks++; if ({ia2.delay, ib2.delay} !== 2'b01) begin errors++; $display("FAIL rm_conflict got %b exp 01", {ia2.delay, ib2.delay}); end
        step();
        drv_a2(1, 0, 4'h0, 10'd7, 32'h0);
        drv_b2(0, 0, 4'h0, 10'd0, 32'h0);
        mid();
        checks++; if ({ia2.delay, ib2.delay} !== 2'b00) begin errors++; $display("FAIL rm_withdraw got %b exp 00", {ia2.delay, ib2.delay}); end
        step();
        drv_a2(0, 0, 4'h0, 10'd0, 32'h0);
        rst_n = 1'b0;
        #1;
        checks++; if (ia2.data_r !== 32'h0) begin errors++; $display("FAIL rm_async_clear got %h exp %h", ia2.data_r, 32'h0); end
        checks++; if (ia1.data_r !== 32'h0) begin errors++; $display("FAIL rm_async_clear_lat1 got %h exp %h", ia1.data_r, 32'h0); end
        mid();
        rst_n = 1'b1;
        step();
        step();
        step();
        mid();
        checks++; if (ia2.data_r !== 32'h0) begin errors++; $display("FAIL rm_inflight_dropped got %h exp %h", ia2.data_r, 32'h0); end
        step();
        drv_a2(1, 0, 4'h0, 10'd5, 32'h0);
        drv_b2(1, 0, 4'h0, 10'd7, 32'h0);
        mid();
        checks++; if ({ia2.delay, ib2.delay} !== 2'b01) begin errors++; $display("FAIL rm_rr_is_a got %b exp 01", {ia2.delay, ib2.delay}); end
        step();
        drv_a2(0, 0, 4'h0, 10'd0, 32'h0);
        drv_b2(0, 0, 4'h0, 10'd0, 32'h0);
        step();
        mid();
        checks++; if (ia2.data_r !== 32'h5) begin errors++; $display("FAIL rm_after_reset_read got %h exp %h", ia2.data_r, 32'h5); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_byte_enables();
        test_no_conflict();
        test_round_robin();
        test_latency2();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
